wb_retire_queue: RTL and testbench

WB_RETIRE_QUEUE -- requirements
Module: wb_retire_queue

---
 rtl/wb_retire_queue.sv | 121 ++++++++++++
 tb/tb_wb_retire_queue.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_retire_queue.sv
// Writeback retire queue: buffers MEM-stage results in a small circular FIFO
// and drains them in order through a regfile write port that may stall.
module wb_retire_queue #(
    parameter int XLEN       = 32,
    parameter int REG_ADDR_W = 5,
    parameter int DEPTH      = 4,
    parameter int CNT_W      = 32
) (
    input  logic                              clk,
    input  logic                              resetn,
    input  logic                              mem2wb_valid_i,
    input  logic [REG_ADDR_W+1+2*XLEN-1:0]    mem2wb_bus_i,
    output logic                              wb_allowin_o,
    input  logic                              flush_i,
    input  logic                              rf_ready_i,
    output logic                              rf_we_o,
    output logic [REG_ADDR_W-1:0]             rf_wdest_o,
    output logic [XLEN-1:0]                   rf_wdata_o,
    output logic [DEPTH*REG_ADDR_W-1:0]       ctl_wb_dest_o,
    output logic                              ctl_wb_busy_o,
    output logic [XLEN-1:0]                   debug_wb_pc_o,
    output logic [CNT_W-1:0]                  retire_cnt_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = PTR_W + 1;
    localparam logic [OCC_W-1:0] FULL_OCC = OCC_W'(DEPTH);

    logic [PTR_W-1:0]      head_ptr;
    logic [PTR_W-1:0]      tail_ptr;
    logic [OCC_W-1:0]      occ;
    logic [DEPTH-1:0]      slot_vld;
    logic [DEPTH-1:0]      slot_we;
    logic [REG_ADDR_W-1:0] slot_wdest  [DEPTH];
    logic [XLEN-1:0]       slot_result [DEPTH];
    logic [XLEN-1:0]       slot_pc     [DEPTH];
    logic [CNT_W-1:0]      retire_cnt;

    logic [REG_ADDR_W-1:0] in_wdest;
    logic                  in_we;
    logic [XLEN-1:0]       in_result;
    logic [XLEN-1:0]       in_pc;

    logic                  head_vld;
    logic                  head_we;
    logic [REG_ADDR_W-1:0] head_wdest;
    logic                  push;
    logic                  retire;

    assign in_pc     = mem2wb_bus_i[XLEN-1:0];
    assign in_result = mem2wb_bus_i[2*XLEN-1:XLEN];
    assign in_we     = mem2wb_bus_i[2*XLEN];
    assign in_wdest  = mem2wb_bus_i[2*XLEN+1 +: REG_ADDR_W];

    // Head qualification is masked by resetn so nothing leaks out while reset is held.
    assign head_vld   = resetn & (occ != '0);
    assign head_we    = slot_we[head_ptr];
    assign head_wdest = slot_wdest[head_ptr];

    assign wb_allowin_o = ((occ != FULL_OCC) | ~resetn) & ~flush_i;
    assign push         = mem2wb_valid_i & wb_allowin_o;
    assign retire       = head_vld & ~flush_i & (~head_we | rf_ready_i);

    assign rf_we_o       = retire & head_we & (head_wdest != '0);
    assign rf_wdest_o    = head_vld ? head_wdest : '0;
    assign rf_wdata_o    = head_vld ? slot_result[head_ptr] : '0;
    assign debug_wb_pc_o = head_vld ? slot_pc[head_ptr] : '0;
    assign ctl_wb_busy_o = head_vld;
    assign retire_cnt_o  = retire_cnt;

    always_comb begin
        ctl_wb_dest_o = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (resetn && slot_vld[i] && slot_we[i]) begin
                ctl_wb_dest_o[i*REG_ADDR_W +: REG_ADDR_W] = slot_wdest[i];
            end
        end
    end

    // Control state: pointers, occupancy, slot valids and the retire counter.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            head_ptr   <= '0;
            tail_ptr   <= '0;
            occ        <= '0;
            slot_vld   <= '0;
            retire_cnt <= '0;
        end else if (flush_i) begin
            head_ptr <= '0;
            tail_ptr <= '0;
            occ      <= '0;
            slot_vld <= '0;
        end else begin
            if (retire) begin
                head_ptr           <= head_ptr + PTR_W'(1);
                slot_vld[head_ptr] <= 1'b0;
                retire_cnt         <= retire_cnt + CNT_W'(1);
            end
            if (push) begin
                tail_ptr           <= tail_ptr + PTR_W'(1);
                slot_vld[tail_ptr] <= 1'b1;
            end
            case ({push, retire})
                2'b10:   occ <= occ + OCC_W'(1);
                2'b01:   occ <= occ - OCC_W'(1);
                default: occ <= occ;
            endcase
        end
    end

    // Slot payload carries no reset; occupancy is tracked by slot_vld.
    always_ff @(posedge clk) begin
        if (push) begin
            slot_we[tail_ptr]     <= in_we;
            slot_wdest[tail_ptr]  <= in_wdest;
            slot_result[tail_ptr] <= in_result;
            slot_pc[tail_ptr]     <= in_pc;
        end
    end

endmodule

// File: tb/tb_wb_retire_queue.sv
// Scoreboard bench for wb_retire_queue: expected regfile writes are queued at
// acceptance and popped whenever the DUT asserts rf_we_o.
module tb_wb_retire_queue;

    localparam int XLEN  = 32;
    localparam int RAW   = 5;
    localparam int DEPTH = 4;
    localparam int CNT_W = 32;

    logic                    clk = 1'b0;
    logic                    resetn = 1'b0;
    logic                    mem2wb_valid_i = 1'b0;
    logic [RAW+1+2*XLEN-1:0] mem2wb_bus_i = '0;
    logic                    wb_allowin_o;
    logic                    flush_i = 1'b0;
    logic                    rf_ready_i = 1'b0;
    logic                    rf_we_o;
    logic [RAW-1:0]          rf_wdest_o;
    logic [XLEN-1:0]         rf_wdata_o;
    logic [DEPTH*RAW-1:0]    ctl_wb_dest_o;
    logic                    ctl_wb_busy_o;
    logic [XLEN-1:0]         debug_wb_pc_o;
    logic [CNT_W-1:0]        retire_cnt_o;

    wb_retire_queue #(
        .XLEN(XLEN), .REG_ADDR_W(RAW), .DEPTH(DEPTH), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .resetn(resetn),
        .mem2wb_valid_i(mem2wb_valid_i), .mem2wb_bus_i(mem2wb_bus_i),
        .wb_allowin_o(wb_allowin_o), .flush_i(flush_i), .rf_ready_i(rf_ready_i),
        .rf_we_o(rf_we_o), .rf_wdest_o(rf_wdest_o), .rf_wdata_o(rf_wdata_o),
        .ctl_wb_dest_o(ctl_wb_dest_o), .ctl_wb_busy_o(ctl_wb_busy_o),
        .debug_wb_pc_o(debug_wb_pc_o), .retire_cnt_o(retire_cnt_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [RAW-1:0]  wdest;
        logic [XLEN-1:0] data;
    } exp_t;

    exp_t sb [$];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rf_we_o === 1'b1) begin
            if (sb.size() == 0) begin
                check("unexpected_we", 64'(rf_wdest_o), 64'hFFFF);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("wr_wdest", 64'(rf_wdest_o), 64'(e.wdest));
                check("wr_wdata", 64'(rf_wdata_o), 64'(e.data));
            end
        end
    end

    task automatic do_reset();
        resetn         = 1'b0;
        mem2wb_valid_i = 1'b0;
        flush_i        = 1'b0;
        repeat (2) @(posedge clk);
        #1 resetn = 1'b1;
        sb.delete();
    endtask

    task automatic push(input logic [RAW-1:0] wd, input logic we, input logic [XLEN-1:0] res,
                        input logic [XLEN-1:0] pc, output int waits);
        logic acc;
        acc   = 1'b0;
        waits = 0;
        mem2wb_valid_i = 1'b1;
        mem2wb_bus_i   = {wd, we, res, pc};
        for (int t = 0; t < 20; t++) begin
            @(negedge clk);
            acc = wb_allowin_o;
            @(posedge clk);
            #1;
            if (acc) break;
            waits++;
        end
        check("push_accepted", 64'(acc), 64'd1);
        if (acc && we && wd != '0) sb.push_back('{wdest: wd, data: res});
    endtask

    task automatic idle();
        mem2wb_valid_i = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int w;
        logic [DEPTH*RAW-1:0] exp_dest;

        // Reset state
        do_reset();
        @(negedge clk);
        check("rst_we",     64'(rf_we_o), 64'd0);
        check("rst_allow",  64'(wb_allowin_o), 64'd1);
        check("rst_busy",   64'(ctl_wb_busy_o), 64'd0);
        check("rst_dest",   64'(ctl_wb_dest_o), 64'd0);
        check("rst_pc",     64'(debug_wb_pc_o), 64'd0);
        check("rst_cnt",    64'(retire_cnt_o), 64'd0);
        check("rst_wdest",  64'(rf_wdest_o), 64'd0);
        check("rst_wdata",  64'(rf_wdata_o), 64'd0);

        // Single write, one-cycle latency
        @(posedge clk); #1;
        rf_ready_i = 1'b1;
        push(5'd3, 1'b1, 32'hDEADBEEF, 32'h1C000000, w);
        idle();
        @(negedge clk);
        check("t1_we",    64'(rf_we_o), 64'd1);
        check("t1_wdest", 64'(rf_wdest_o), 64'd3);
        check("t1_wdata", 64'(rf_wdata_o), 64'hDEADBEEF);
        check("t1_pc",    64'(debug_wb_pc_o), 64'h1C000000);
        check("t1_cnt0",  64'(retire_cnt_o), 64'd0);
        @(posedge clk); #1;
        check("t1_cnt1",  64'(retire_cnt_o), 64'd1);
        @(negedge clk);
        check("t1_busy",  64'(ctl_wb_busy_o), 64'd0);

        // Fill under backpressure, then drain
        do_reset();
        rf_ready_i = 1'b0;
        for (int i = 0; i < 4; i++)
            push(RAW'(5 + i), 1'b1, 32'hA000_0000 + 32'(i), 32'h1C00_0100 + 32'(4 * i), w);
        idle();
        @(negedge clk);
        exp_dest = {5'd8, 5'd7, 5'd6, 5'd5};
        check("t2_allow", 64'(wb_allowin_o), 64'd0);
        check("t2_busy",  64'(ctl_wb_busy_o), 64'd1);
        check("t2_dest",  64'(ctl_wb_dest_o), 64'(exp_dest));
        check("t2_pc",    64'(debug_wb_pc_o), 64'h1C00_0100);
        check("t2_stall", 64'(rf_we_o), 64'd0);
        @(posedge clk); #1;
        rf_ready_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("t2_drain_we", 64'(rf_we_o), 64'd1);
            @(posedge clk); #1;
        end
        @(negedge clk);
        check("t2_empty", 64'(ctl_wb_busy_o), 64'd0);
        check("t2_cnt",   64'(retire_cnt_o), 64'd4);

        // we=0 and r0 entries retire without writing
        do_reset();
        rf_ready_i = 1'b0;
        push(5'd9, 1'b0, 32'h1111_1111, 32'h1C00_0200, w);
        push(5'd0, 1'b1, 32'h2222_2222, 32'h1C00_0204, w);
        idle();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("t3_we_stall", 64'(rf_we_o), 64'd0);
            check("t3_cnt1",     64'(retire_cnt_o), 64'd1);
            check("t3_busy",     64'(ctl_wb_busy_o), 64'd1);
        end
        @(posedge clk); #1;
        rf_ready_i = 1'b1;
        @(negedge clk);
        check("t3_we_r0", 64'(rf_we_o), 64'd0);
        @(posedge clk); #1;
        check("t3_cnt2",  64'(retire_cnt_o), 64'd2);
        @(negedge clk);
        check("t3_empty", 64'(ctl_wb_busy_o), 64'd0);

        // Wrap-around: ten back-to-back pushes
        do_reset();
        rf_ready_i = 1'b1;
        for (int i = 0; i < 10; i++) begin
            push(RAW'(1 + i), 1'b1, 32'h0F0F_0000 ^ (32'h1111_1111 * 32'(i)), 32'h1C00_1000 + 32'(4 * i), w);
            check("t4_allow_b2b", 64'(w), 64'd0);
        end
        idle();
        repeat (2) @(posedge clk);
        #1;
        check("t4_cnt",    64'(retire_cnt_o), 64'd10);
        check("t4_drained", 64'(sb.size()), 64'd0);

        // Flush with a coincident offer
        rf_ready_i = 1'b0;
        for (int i = 0; i < 3; i++)
            push(RAW'(10 + i), 1'b1, 32'hB000_0000 + 32'(i), 32'h1C00_2000 + 32'(4 * i), w);
        idle();
        @(posedge clk); #1;
        flush_i        = 1'b1;
        rf_ready_i     = 1'b1;
        mem2wb_valid_i = 1'b1;
        mem2wb_bus_i   = {5'd13, 1'b1, 32'hBAD0_BAD0, 32'h1C00_200C};
        sb.delete();
        @(negedge clk);
        check("t5_we_flush", 64'(rf_we_o), 64'd0);
        check("t5_allow",    64'(wb_allowin_o), 64'd0);
        @(posedge clk); #1;
        flush_i        = 1'b0;
        mem2wb_valid_i = 1'b0;
        @(negedge clk);
        check("t5_busy", 64'(ctl_wb_busy_o), 64'd0);
        check("t5_dest", 64'(ctl_wb_dest_o), 64'd0);
        check("t5_cnt",  64'(retire_cnt_o), 64'd10);
        @(posedge clk); #1;
        push(5'd14, 1'b1, 32'hC0DE_0014, 32'h1C00_3000, w);
        idle();
        repeat (2) @(posedge clk);
        #1;
        check("t5_cnt_after", 64'(retire_cnt_o), 64'd11);

        // Mid-run reset
        rf_ready_i = 1'b0;
        push(5'd20, 1'b1, 32'hD000_0020, 32'h1C00_4000, w);
        push(5'd21, 1'b1, 32'hD000_0021, 32'h1C00_4004, w);
        idle();
        @(posedge clk); #1;
        resetn     = 1'b0;
        rf_ready_i = 1'b1;
        sb.delete();
        @(negedge clk);
        check("t6_we_in_rst", 64'(rf_we_o), 64'd0);
        @(posedge clk); #1;
        resetn = 1'b1;
        @(negedge clk);
        check("t6_we",    64'(rf_we_o), 64'd0);
        check("t6_busy",  64'(ctl_wb_busy_o), 64'd0);
        check("t6_cnt",   64'(retire_cnt_o), 64'd0);
        check("t6_allow", 64'(wb_allowin_o), 64'd1);
        @(posedge clk); #1;
        push(5'd22, 1'b1, 32'hE000_0022, 32'h1C00_5000, w);
        idle();
        repeat (2) @(posedge clk);
        #1;
        check("t6_cnt_after", 64'(retire_cnt_o), 64'd1);
        check("sb_drained",   64'(sb.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
